fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a show-ahead FIFO and sends each as an
// 8N1-style UART frame (start, DATA_WIDTH data bits LSB first, stop).
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-high reset
//   en        - allows a new frame to start (never aborts one)
//   fifo_data - head word of the upstream FIFO
//   fifo_val  - upstream FIFO non-empty
//   read      - one-cycle pop strobe, high in the first START cycle
//   tx        - serial line, idle high
//   busy      - high from START through STOP
//   done      - one-cycle pulse on the last STOP cycle
//
// Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit.

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_val,
    output logic                  read,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [BAUD_W-1:0]     r_baud;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_read;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  r_par;
`endif

    logic w_start;
    logic w_bit_end;
    logic w_tx;
    logic w_busy;
    logic w_done;

    assign w_start   = (r_state == S_IDLE) && en && fifo_val;
    assign w_bit_end = (r_baud == BAUD_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and line outputs
    always_comb begin
        w_next = r_state;
        w_tx   = 1'b1;
        w_busy = 1'b1;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_start) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && (r_idx == IDX_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx = r_par;
                if (w_bit_end) begin
                    w_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_tx = 1'b1;
                if (w_bit_end) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: baud/bit counters, shift register, pop strobe.
    // The word is captured on the start edge, so later changes on the
    // FIFO side cannot disturb the frame; the pop follows one cycle on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_read  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_read <= w_start;
            if (r_state == S_IDLE) begin
                r_baud <= '0;
                r_idx  <= '0;
                if (w_start) begin
                    r_shift <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_par   <= ^fifo_data;
`endif
                end
            end else begin
                if (w_bit_end) begin
                    r_baud <= '0;
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                if ((r_state == S_DATA) && w_bit_end) begin
                    r_shift <= r_shift >> 1;
                    r_idx   <= r_idx + 1'b1;
                end
            end
        end
    end

    assign read = r_read;
    assign tx   = w_tx;
    assign busy = w_busy;
    assign done = w_done;

endmodule
